// File: rtl/vedic_mult_seq.sv
// vedic_mult_seq: sequential multiplier that walks a 4x4 Urdhva digit unit over all digit pairs; `VEDIC_MULT_ACC_EN adds a running product accumulator
module vedic_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
`ifdef VEDIC_MULT_ACC_EN
    ,
    input  logic               acc_clr,
    output logic [2*WIDTH+7:0] acc
`endif
);
    localparam int D = WIDTH / 4;
    localparam int K = D * D;
    localparam int CW = $clog2(K);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic [CW-1:0] cnt;
    logic [3:0] ad, bd;
    logic [7:0] pp;
    logic [2*WIDTH-1:0] sh, sum;
    int i, j;
    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        logic [3:0] s;
        p = '0;
        s = '0;
        // vertical-crosswise: each column's cross products plus the carry from the previous column
        for (int k = 0; k < 7; k++) begin
            for (int m = 0; m < 4; m++)
                for (int n = 0; n < 4; n++)
                    if (m + n == k) s = s + {3'b000, x[m] & y[n]};
            p[k] = s[0];
            s = s >> 1;
        end
        p[7] = s[0];
        return p;
    endfunction
    function automatic logic [2*WIDTH-1:0] rca(input logic [2*WIDTH-1:0] x, input logic [2*WIDTH-1:0] y);
        logic [2*WIDTH-1:0] s;
        logic c;
        c = 1'b0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            s[k] = x[k] ^ y[k] ^ c;
            c = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
        end
        return s;
    endfunction
    always_comb begin
        i = int'(cnt) / D;
        j = int'(cnt) % D;
        ad = a_r[4*i +: 4];
        bd = b_r[4*j +: 4];
        pp = vedic4(ad, bd);
        sh = (2*WIDTH)'(pp) << (4 * (i + j));
        sum = rca(product, sh);
    end
    always_comb begin
        state_nx = (state == IDLE) ? (in_valid ? CALC : IDLE) :
                   (state == CALC) ? ((cnt == CW'(K - 1)) ? DONE : CALC) :
                   (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r <= '0;
            b_r <= '0;
            cnt <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_r <= a;
                b_r <= b;
                cnt <= '0;
                product <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                product <= sum;
            end
        end
    end
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state == CALC || state == DONE;
`ifdef VEDIC_MULT_ACC_EN
    logic hs;
    assign hs = out_valid && out_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) acc <= '0;
        else if (acc_clr || hs) acc <= (acc_clr ? '0 : acc) + (hs ? (2*WIDTH+8)'(product) : '0);
    end
`endif
endmodule
